// File: rtl/bus_arbiter_rr6.sv
// bus_arbiter_rr6: round-robin owner of a shared 16-bit bus mux with hold limit and one-cycle turnaround gap.
// Optional macro ARB_LOCK_EN: owner-held lock suspends the hold limit while the owner keeps requesting.
module bus_arbiter_rr6 #(
    parameter int NUM_REQ   = 6,
    parameter int MAX_HOLD  = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] req,
    input  logic       lock,
    output logic [5:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       expired
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN  = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    localparam logic [5:0]           REQ_MASK_C = 6'((7'd1 << NUM_REQ) - 7'd1);
    localparam logic [CNT_WIDTH-1:0] MAX_HOLD_C = CNT_WIDTH'(MAX_HOLD);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE_C  = CNT_WIDTH'(1);

    function automatic logic [5:0] onehot6(input logic [2:0] idx);
        logic [5:0] v;
        case (idx)
            3'd0:    v = 6'b000001;
            3'd1:    v = 6'b000010;
            3'd2:    v = 6'b000100;
            3'd3:    v = 6'b001000;
            3'd4:    v = 6'b010000;
            3'd5:    v = 6'b100000;
            default: v = 6'b000000;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] k);
        logic [2:0] n;
        if (k >= 3'(NUM_REQ - 1)) begin
            n = 3'd0;
        end else begin
            n = k + 3'd1;
        end
        return n;
    endfunction

    state_t               state_r, state_s;
    logic [CNT_WIDTH-1:0] cnt_r, cnt_s;
    logic [2:0]           ptr_r, ptr_s;
    logic [5:0]           grant_r, grant_s;
    logic [2:0]           sel_r, sel_s;
    logic                 busy_r, busy_s;
    logic                 expired_r, expired_s;

    logic [5:0] req_m_s;
    logic       owner_req_s;
    logic       lock_hold_s;
    logic       win_found_s;
    logic [2:0] win_idx_s;
    logic [3:0] scan_s;

    assign req_m_s     = req & REQ_MASK_C;
    assign owner_req_s = |(req_m_s & grant_r);

`ifdef ARB_LOCK_EN
    assign lock_hold_s = lock;
`else
    assign lock_hold_s = lock & 1'b0;
`endif

    // Rotating priority scan: first masked request at or above the pointer, wrapping at NUM_REQ.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        scan_s      = 4'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_s = {1'b0, ptr_r} + 4'(i);
            if (scan_s >= 4'(NUM_REQ)) begin
                scan_s = scan_s - 4'(NUM_REQ);
            end else begin
                scan_s = scan_s;
            end
            if (!win_found_s && req_m_s[scan_s[2:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = scan_s[2:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and next-output logic; sel only moves on a new grant so the mux never switches mid-transfer.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        ptr_s     = ptr_r;
        grant_s   = grant_r;
        sel_s     = sel_r;
        busy_s    = busy_r;
        expired_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_s = ST_OWN;
                    grant_s = onehot6(win_idx_s);
                    sel_s   = win_idx_s;
                    busy_s  = 1'b1;
                    cnt_s   = CNT_ONE_C;
                end else begin
                    grant_s = 6'b000000;
                    busy_s  = 1'b0;
                end
            end
            ST_OWN: begin
                if (!owner_req_s) begin
                    state_s = ST_GAP;
                    grant_s = 6'b000000;
                    busy_s  = 1'b0;
                    ptr_s   = next_idx(sel_r);
                    cnt_s   = '0;
                end else if (lock_hold_s) begin
                    if (cnt_r < MAX_HOLD_C) begin
                        cnt_s = cnt_r + CNT_ONE_C;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else if (cnt_r >= MAX_HOLD_C) begin
                    state_s   = ST_GAP;
                    grant_s   = 6'b000000;
                    busy_s    = 1'b0;
                    ptr_s     = next_idx(sel_r);
                    cnt_s     = '0;
                    expired_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE_C;
                end
            end
            ST_GAP: begin
                state_s = ST_IDLE;
                grant_s = 6'b000000;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = 6'b000000;
                busy_s  = 1'b0;
                cnt_s   = '0;
            end
        endcase
    end

    // State and registered outputs; reset drops ownership at once without a gap or expiry pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            ptr_r     <= 3'd0;
            grant_r   <= 6'b000000;
            sel_r     <= 3'b000;
            busy_r    <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            ptr_r     <= ptr_s;
            grant_r   <= grant_s;
            sel_r     <= sel_s;
            busy_r    <= busy_s;
            expired_r <= expired_s;
        end
    end

    assign grant   = grant_r;
    assign sel     = sel_r;
    assign busy    = busy_r;
    assign expired = expired_r;

endmodule
